control_fsm: RTL and testbench

//  Multi-cycle control sequencer upstream of the Rdest decoder. Fetches and decodes 16-bit instructions
//  ({op[15:12], rdest[11:8], ext[7:4], src[3:0]}), drives memory/ALU/PC strobes, and emits the 4-bit
//  reg_en code for one writeback cycle per writing instruction. reg_en=0 means no write; r0 is constant zero.

---
 rtl/control_fsm.sv | 207 ++++++++++++++++++++
 tb/tb_control_fsm.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_fsm.sv
// Multi-cycle fetch/decode/execute sequencer producing memory, ALU, PC strobes and the reg_en writeback code.
// Latency: 4 cycles per ALU instruction with zero-wait fetch (FETCH, DECODE, EXEC, WB); memory ops add S_MEM wait cycles.
// Backpressure: stalls in S_FETCH/S_MEM until mem_ready; after MEM_TIMEOUT waiting cycles sets sticky err and drops the access.
module control_fsm #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic        mem_ready,
    output logic [3:0]  reg_en,
    output logic [3:0]  src,
    output logic [7:0]  alu_op,
    output logic        imm_sel,
    output logic        wb_sel,
    output logic        ir_en,
    output logic        pc_en,
    output logic        mem_re,
    output logic        mem_we,
    output logic        err
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    // Last waiting cycle index: the MEM_TIMEOUT-th cycle without mem_ready is the one that times out.
    localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_t          state;
    state_t          state_nxt;
    logic [15:0]     ir;
    logic [TO_W-1:0] wait_cnt;
    logic [TO_W-1:0] wait_cnt_nxt;
    logic            err_q;
    logic            err_nxt;
    logic            ir_load;

    // Instruction fields of the latched instruction.
    logic [3:0] op;
    logic [3:0] rdest;
    logic [3:0] ext;
    logic [3:0] src_f;

    // Instruction classes.
    logic is_rtype;
    logic is_imm_alu;
    logic is_cmpi;
    logic is_load;
    logic is_stor;
    logic writes_alu;
    logic wait_hit;

    assign op    = ir[15:12];
    assign rdest = ir[11:8];
    assign ext   = ir[7:4];
    assign src_f = ir[3:0];

    assign wait_hit = (wait_cnt == WAIT_LAST);

    // Classify the latched instruction; anything unrecognised falls through as a NOP.
    always_comb begin
        is_rtype   = 1'b0;
        is_imm_alu = 1'b0;
        is_cmpi    = 1'b0;
        is_load    = 1'b0;
        is_stor    = 1'b0;
        case (op)
            4'b0000: is_rtype = 1'b1;
            4'b0001, 4'b0010, 4'b0011,
            4'b0101, 4'b1001, 4'b1101: is_imm_alu = 1'b1;
            4'b1011: is_cmpi = 1'b1;
            4'b0100: begin
                is_load = (ext == 4'b0000);
                is_stor = (ext == 4'b0100);
            end
            default: ;
        endcase
        // CMP (R-type with ext=1011) only sets flags, so it has no writeback.
        writes_alu = (is_rtype && (ext != 4'b1011)) || is_imm_alu;
    end

    // State, instruction register, wait counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            ir       <= 16'h0;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            err_q    <= err_nxt;
            if (ir_load) begin
                ir <= instr;
            end
        end
    end

    // Next-state and strobe generation; all outputs are forced low while reset is asserted.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        err_nxt      = err_q;
        ir_load      = 1'b0;
        reg_en       = 4'h0;
        src          = 4'h0;
        alu_op       = 8'h00;
        imm_sel      = 1'b0;
        wb_sel       = 1'b0;
        ir_en        = 1'b0;
        pc_en        = 1'b0;
        mem_re       = 1'b0;
        mem_we       = 1'b0;

        // Operand selects stay stable from EXEC through writeback.
        if (state == S_EXEC || state == S_MEM || state == S_WB) begin
            src     = src_f;
            alu_op  = {op, ext};
            imm_sel = is_imm_alu || is_cmpi;
            wb_sel  = is_load;
        end

        case (state)
            S_FETCH: begin
                mem_re = 1'b1;
                if (mem_ready) begin
                    // A ready on the timeout cycle still completes the fetch.
                    ir_en        = 1'b1;
                    ir_load      = 1'b1;
                    state_nxt    = S_DECODE;
                    wait_cnt_nxt = '0;
                end else if (wait_hit) begin
                    // Give up on this attempt; refetch from the same PC.
                    err_nxt      = 1'b1;
                    wait_cnt_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt + TO_W'(1);
                end
            end

            S_DECODE: begin
                pc_en     = 1'b1;
                state_nxt = S_EXEC;
            end

            S_EXEC: begin
                wait_cnt_nxt = '0;
                if (writes_alu) begin
                    state_nxt = S_WB;
                end else if (is_load || is_stor) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_FETCH;
                end
            end

            S_MEM: begin
                mem_re = is_load;
                mem_we = is_stor;
                if (mem_ready) begin
                    state_nxt    = is_load ? S_WB : S_FETCH;
                    wait_cnt_nxt = '0;
                end else if (wait_hit) begin
                    // Abandon the access entirely; no writeback for a timed-out load.
                    err_nxt      = 1'b1;
                    state_nxt    = S_FETCH;
                    wait_cnt_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt + TO_W'(1);
                end
            end

            S_WB: begin
                // rdest=0 naturally yields reg_en=0, i.e. no write to the constant-zero register.
                reg_en       = rdest;
                state_nxt    = S_FETCH;
                wait_cnt_nxt = '0;
            end

            default: begin
                state_nxt    = S_FETCH;
                wait_cnt_nxt = '0;
            end
        endcase

        if (!rst_n) begin
            reg_en  = 4'h0;
            src     = 4'h0;
            alu_op  = 8'h00;
            imm_sel = 1'b0;
            wb_sel  = 1'b0;
            ir_en   = 1'b0;
            pc_en   = 1'b0;
            mem_re  = 1'b0;
            mem_we  = 1'b0;
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm with MEM_TIMEOUT=4.
// Inputs are driven 1 time unit after the rising edge and outputs checked 1 unit later.
// Every comparison goes through check(); summary line reports totals.
module tb_control_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr;
    logic        mem_ready;
    logic [3:0]  reg_en;
    logic [3:0]  src;
    logic [7:0]  alu_op;
    logic        imm_sel;
    logic        wb_sel;
    logic        ir_en;
    logic        pc_en;
    logic        mem_re;
    logic        mem_we;
    logic        err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    control_fsm #(
        .MEM_TIMEOUT(4),
        .TO_W       (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .instr    (instr),
        .mem_ready(mem_ready),
        .reg_en   (reg_en),
        .src      (src),
        .alu_op   (alu_op),
        .imm_sel  (imm_sel),
        .wb_sel   (wb_sel),
        .ir_en    (ir_en),
        .pc_en    (pc_en),
        .mem_re   (mem_re),
        .mem_we   (mem_we),
        .err      (err)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // All outputs except err must be zero.
    task automatic check_quiet(input string tag);
        check({tag, "_bus"}, {reg_en, src, alu_op}, 16'h0000);
        check({tag, "_strb"}, {10'h0, imm_sel, wb_sel, ir_en, pc_en, mem_re, mem_we}, 16'h0000);
    endtask

    // Fetch with immediate ready, then the decode cycle; leaves the DUT in S_EXEC.
    task automatic fetch_decode(input logic [15:0] iw);
        instr = iw; mem_ready = 1'b1;
        #1;
        check("fetch_re", mem_re, 1);
        check("fetch_ir_en", ir_en, 1);
        check("fetch_pc_en", pc_en, 0);
        tick();
        instr = 16'hFFFF;
        #1;
        check("dec_pc_en", pc_en, 1);
        check("dec_re", {mem_re, mem_we}, 0);
        check("dec_reg_en", reg_en, 0);
        tick();
    endtask

    // ALU-class instruction; mem_ready is left high after fetch to show it is ignored.
    task automatic alu_instr(input logic [15:0] iw, input logic [7:0] e_op, input logic [3:0] e_src,
                             input logic e_imm, input logic e_wb, input logic [3:0] e_reg);
        fetch_decode(iw);
        #1;
        check("exe_alu_op", alu_op, e_op);
        check("exe_src", src, e_src);
        check("exe_imm_sel", imm_sel, e_imm);
        check("exe_reg_en", reg_en, 0);
        check("exe_pc_en", pc_en, 0);
        tick();
        if (e_wb) begin
            #1;
            check("wb_reg_en", reg_en, e_reg);
            check("wb_wb_sel", wb_sel, 0);
            check("wb_alu_op", alu_op, e_op);
            tick();
        end
        mem_ready = 1'b0;
        #1;
        check("ret_fetch_re", mem_re, 1);
        check("ret_reg_en", reg_en, 0);
    endtask

    // LOAD/STOR with two wait cycles then ready on the third MEM cycle.
    task automatic mem_instr(input logic [15:0] iw, input logic e_load, input logic [7:0] e_op,
                             input logic [3:0] e_reg);
        fetch_decode(iw);
        mem_ready = 1'b0;
        #1;
        check("mexe_alu_op", alu_op, e_op);
        check("mexe_wb_sel", wb_sel, e_load);
        tick();
        for (int i = 0; i < 3; i++) begin
            mem_ready = (i == 2);
            #1;
            check("mem_re", mem_re, e_load);
            check("mem_we", mem_we, !e_load);
            check("mem_reg_en", reg_en, 0);
            tick();
        end
        mem_ready = 1'b0;
        if (e_load) begin
            #1;
            check("ld_wb_reg_en", reg_en, e_reg);
            check("ld_wb_sel", wb_sel, 1);
            check("ld_wb_re", mem_re, 0);
            tick();
        end
        #1;
        check("mret_fetch", {mem_re, mem_we}, 2'b10);
        check("mret_reg_en", reg_en, 0);
    endtask

    initial begin
        rst_n = 1'b0; instr = 16'h0; mem_ready = 1'b0;
        #2;
        check_quiet("rst0");
        check("rst0_err", err, 0);
        tick();
        tick();
        check_quiet("rst1");
        rst_n = 1'b1;
        #1;
        check("post_rst_re", mem_re, 1);
        check("post_rst_err", err, 0);

        // ALU vectors: ADD, ADDI, CMPI, CMP, NOP, ADD into r0.
        alu_instr(16'h0355, 8'h05, 4'h5, 1'b0, 1'b1, 4'h3);
        alu_instr(16'h5702, 8'h50, 4'h2, 1'b1, 1'b1, 4'h7);
        alu_instr(16'hB702, 8'hB0, 4'h2, 1'b1, 1'b0, 4'h0);
        alu_instr(16'h00B1, 8'h0B, 4'h1, 1'b0, 1'b0, 4'h0);
        alu_instr(16'h7123, 8'h72, 4'h3, 1'b0, 1'b0, 4'h0);
        alu_instr(16'h0012, 8'h01, 4'h2, 1'b0, 1'b1, 4'h0);

        // Memory vectors.
        mem_instr(16'h4402, 1'b1, 8'h40, 4'h4);
        mem_instr(16'h4342, 1'b0, 8'h44, 4'h0);
        check("mem_err", err, 0);

        // Ready arriving on the final permitted wait cycle completes the fetch without error.
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bnd_wait_ir_en", ir_en, 0);
            tick();
        end
        alu_instr(16'h0355, 8'h05, 4'h5, 1'b0, 1'b1, 4'h3);
        check("bnd_err", err, 0);

        // Fetch timeout: four waiting cycles, then err, PC not advanced, fetch retried.
        for (int i = 0; i < 4; i++) begin
            #1;
            check("to_wait_err", err, 0);
            check("to_wait_pc_en", pc_en, 0);
            tick();
        end
        #1;
        check("to_err", err, 1);
        check("to_retry_re", mem_re, 1);
        check("to_pc_en", pc_en, 0);
        alu_instr(16'h0355, 8'h05, 4'h5, 1'b0, 1'b1, 4'h3);
        check("to_err_sticky", err, 1);

        // Reset asserted in the writeback cycle of ADD r9.
        fetch_decode(16'h0955);
        mem_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check_quiet("wbrst");
        check("wbrst_err", err, 0);
        tick();
        check_quiet("wbrst_hold");
        rst_n = 1'b1;
        #1;
        check("wbrst_rel_re", mem_re, 1);
        check("wbrst_rel_reg_en", reg_en, 0);
        tick();
        check("wbrst_fetch_reg_en", reg_en, 0);
        check("wbrst_fetch_re", mem_re, 1);

        // MEM timeout on a LOAD: abandon, no writeback, back to fetch with err.
        fetch_decode(16'h4402);
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            check("mto_re", mem_re, 1);
            check("mto_err", err, 0);
            tick();
        end
        #1;
        check("mto_err_set", err, 1);
        check("mto_fetch", {mem_re, mem_we}, 2'b10);
        check("mto_reg_en", reg_en, 0);
        check("mto_wb_sel", wb_sel, 0);
        tick();
        check("mto_reg_en2", reg_en, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
